// File: rtl/siso_sr.sv
// siso_sr: serial-in, serial-out shift register.
// A single-bit stream entering on SI leaves on SO delayed by DEPTH clock
// cycles. An asynchronous active-low clear loads every stage with its
// RESET_VALUE bit, discarding any bits in flight.
module siso_sr #(
   parameter int                 DEPTH       = 4,
   parameter logic [DEPTH-1:0]   RESET_VALUE = '0
) (
   input  logic clk,
   input  logic clear,
   input  logic SI,
   output logic SO
);

   // stage[0] is nearest SI, stage[DEPTH-1] drives SO.
   logic [DEPTH-1:0] stage;

   // Shift one position per rising edge; clear overrides the clock immediately.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         stage <= RESET_VALUE;
      end else begin
         stage[0] <= SI;
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   // SO comes straight from the last flop, so there is no SI->SO combinational path.
   assign SO = stage[DEPTH-1];

endmodule

// File: tb/tb_siso_sr.sv
// tb_siso_sr: self-checking bench for siso_sr at DEPTH 4, 1 and 8.
module tb_siso_sr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic clear;
   logic si4, si1, si8;
   logic so4, so1, so8;

   siso_sr #(.DEPTH(4)) dut4 (
      .clk   (clk),
      .clear (clear),
      .SI    (si4),
      .SO    (so4)
   );

   siso_sr #(.DEPTH(1)) dut1 (
      .clk   (clk),
      .clear (clear),
      .SI    (si1),
      .SO    (so1)
   );

   siso_sr #(.DEPTH(8), .RESET_VALUE(8'hFF)) dut8 (
      .clk   (clk),
      .clear (clear),
      .SI    (si8),
      .SO    (so8)
   );

   int errors = 0;
   int checks = 0;

   // Scoreboard for the DEPTH=4 instance: every driven SI bit is pushed, and
   // one entry is popped per edge as the expected SO after that edge.
   logic q4[$];

   typedef struct {
      logic si;
      logic so;
   } vec_t;
   vec_t vecs[12];

   function automatic void check(string name, logic act, logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endfunction

   // After clear, the first DEPTH-1 edges show reset bits (all zero for dut4).
   task automatic sb_reset();
      q4.delete();
      repeat (3) q4.push_back(1'b0);
   endtask

   // One clock for dut4: drive SI at the falling edge, compare just after the rising edge.
   task automatic step(input logic v);
      logic exp;
      @(negedge clk);
      si4 = v;
      q4.push_back(v);
      @(posedge clk);
      #1;
      exp = q4.pop_front();
      check("sb_so4", so4, exp);
   endtask

   initial begin
      logic [11:0] pat_si;
      logic [11:0] pat_so;
      pat_si = 12'b1011_0010_0000;
      pat_so = 12'b1111_0110_0100;
      for (int i = 0; i < 12; i++) begin
         vecs[i].si = pat_si[11-i];
         vecs[i].so = pat_so[11-i];
      end

      si4 = 1'b0;
      si1 = 1'b0;
      si8 = 1'b0;
      clear = 1'b1;
      #1;
      clear = 1'b0;

      // Reset held for two cycles with SI toggling.
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         si4 = ~si4;
         si1 = ~si1;
         si8 = ~si8;
         @(posedge clk);
         #1;
         check("reset_so4", so4, 1'b0);
         check("reset_so1", so1, 1'b0);
         check("reset_so8", so8, 1'b1);
      end

      // Release just after an edge; constant fill with SI=1.
      si1 = 1'b0;
      si8 = 1'b0;
      clear = 1'b1;
      sb_reset();
      for (int e = 1; e <= 14; e++) begin
         step(1'b1);
         check("fill_so4", so4, (e >= 4) ? 1'b1 : 1'b0);
      end

      // Pattern table: chain still holds 1s, so the first three outputs are 1.
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].si);
         check("pattern_so4", so4, vecs[i].so);
      end

      // Refill with 1s, then drop clear between clock edges.
      for (int e = 1; e <= 4; e++) step(1'b1);
      check("prefill_so4", so4, 1'b1);
      @(posedge clk);
      #3;
      clear = 1'b0;
      #1;
      check("async_clear_so4", so4, 1'b0);
      check("async_clear_so8", so8, 1'b1);
      @(posedge clk);
      #1;
      check("held_clear_so4", so4, 1'b0);

      // Release with SI=1; SO returns to 1 after the 4th edge.
      clear = 1'b1;
      sb_reset();
      for (int e = 1; e <= 4; e++) begin
         step(1'b1);
         check("post_clear_so4", so4, (e == 4) ? 1'b1 : 1'b0);
      end

      // DEPTH=1 pulse and DEPTH=8 reset-value drain.
      @(posedge clk);
      #3;
      clear = 1'b0;
      #1;
      check("d8_reset_so8", so8, 1'b1);
      check("d1_reset_so1", so1, 1'b0);
      @(posedge clk);
      #1;
      clear = 1'b1;
      si8 = 1'b0;
      @(negedge clk);
      si1 = 1'b1;
      @(posedge clk);
      #1;
      check("d1_pulse_so1", so1, 1'b1);
      check("d8_drain_so8", so8, 1'b1);
      for (int e = 2; e <= 9; e++) begin
         @(negedge clk);
         si1 = 1'b0;
         @(posedge clk);
         #1;
         check("d1_after_so1", so1, 1'b0);
         check("d8_drain_so8", so8, (e >= 8) ? 1'b0 : 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/siso_sr.md
# siso_sr

Serial-in, serial-out shift register: a single-bit stream enters on `SI` and leaves on `SO` delayed by a fixed number of clock cycles. It is a pipeline delay/alignment element for serial data paths, with an asynchronous clear that empties the chain.

## Interface
- `DEPTH`, default 4: number of register stages (must be ≥ 1); sets the SI→SO latency in cycles.
- `RESET_VALUE`, default all-zero (`DEPTH` bits): value every stage takes while clear is asserted. Bit `i` maps to stage `i`; stage 0 is nearest `SI`.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `clear`  input  1  reset. One clock; reset is asynchronous and active-low: `clear` = 0 forces all stages to `RESET_VALUE` immediately, independent of `clk`.
- `SI`  input  1  serial data in, sampled on each rising edge of `clk`.
- `SO`  output  1  serial data out; driven directly by the last stage, stage `DEPTH-1`.

## Operation
- Internal state: a `DEPTH`-bit chain, `stage[0]` … `stage[DEPTH-1]`.
- While `clear` = 0: every stage holds its `RESET_VALUE` bit and `SO` = `RESET_VALUE[DEPTH-1]` (0 by default). `SI` and `clk` edges are ignored.
- On each rising `clk` edge while `clear` = 1, all stages update together:
  - `stage[0]` ← `SI`
  - `stage[i]` ← `stage[i-1]` for `i` = 1 … `DEPTH-1`
  - the old `stage[DEPTH-1]` is discarded.
- No shift enable. The register shifts on every clock edge outside reset.
- `SO` is a register output with no combinational path from `SI`.
- `DEPTH` = 1 degenerates to a single D flip-flop with asynchronous clear.

## Timing
- Latency: the `SI` value sampled at rising edge `k` appears on `SO` right after edge `k + DEPTH - 1`, i.e. on the `DEPTH`-th edge counting edge `k` as the first.
- Default `DEPTH` = 4: `SO` follows `SI` delayed by 4 cycles.
- Assertion of `clear` (falling edge) takes effect immediately, with no clock needed. `SO` goes to its reset value within the same time step.
- Reset applied mid-stream discards all bits in flight. After release, `SO` shows reset-value bits for the next `DEPTH-1` edges before the first new `SI` sample arrives.
- Release of `clear` (0→1) is synchronous in effect. The first shift happens on the first rising edge at which `clear` is already 1.
- `clear` and a clock edge in the same time step: the clear wins, and the chain holds `RESET_VALUE`.
- `SI` must meet setup/hold around the rising edge. There are no other handshakes.

## Test plan
- Reset: hold `clear` = 0 for 2 cycles with `SI` toggling → `SO` = 0 throughout.
- Constant fill, `DEPTH` = 4:
  - stimulus: release `clear`, then hold `SI` = 1 →
  - response: `SO` = 0 after edges 1–3, `SO` = 1 after edge 4, and stays 1 for 10 further cycles.
- Pattern, `DEPTH` = 4: drive `SI` = 1,0,1,1,0,0,1,0 on consecutive edges → `SO` reproduces 1,0,1,1,0,0,1,0 starting after the 4th edge, exactly 4 cycles late.
- Asynchronous clear mid-stream:
  - stimulus: fill with 1s, then drop `clear` between clock edges →
  - response: `SO` goes to 0 immediately, without waiting for a clock edge.
  - After release with `SI` = 1, `SO` returns to 1 after the 4th edge.
- Parameter sweep:
  - `DEPTH` = 1: a single 1 pulse on `SI` → appears on `SO` one edge later.
  - `DEPTH` = 8 with `RESET_VALUE` = 8'hFF: `SO` = 1 during reset; with `SI` = 0 after release, `SO` falls to 0 after the 8th edge.
